// File: rtl/stream_packer_if.sv
//------------------------------------------------------------------------------
// stream_packer_if : narrow input / 64-bit output stream bundle for stream_packer
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface stream_packer_if #(
  parameter int IN_W = 16
);
  localparam int RATIO = 64 / IN_W;
  localparam int LW    = $clog2(RATIO + 1);

  logic [IN_W-1:0] in;
  logic            in_isReady;
  logic            in_canReceive;
  logic            in_isLast;
  logic [63:0]     out;
  logic            out_isReady;
  logic            out_canReceive;
  logic            out_isLast;
  logic [LW-1:0]   out_numLanes;

  // Packer side
  modport slave (
    input  in, in_isReady, in_isLast, out_canReceive,
    output in_canReceive, out, out_isReady, out_isLast, out_numLanes
  );

  // Environment side: narrow source plus wide sink
  modport master (
    output in, in_isReady, in_isLast, out_canReceive,
    input  in_canReceive, out, out_isReady, out_isLast, out_numLanes
  );
endinterface

`default_nettype wire

// File: rtl/stream_packer.sv
//------------------------------------------------------------------------------
// stream_packer : packs IN_W-bit items little-endian into 64-bit words.
// Optional macro STREAM_PACKER_ZERO_FILL_EN zeroes lanes beyond out_numLanes.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module stream_packer #(
  parameter int IN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  stream_packer_if.slave   bus
);
  localparam int RATIO = 64 / IN_W;
  localparam int LW    = $clog2(RATIO + 1);
  localparam int IW    = (RATIO > 1) ? $clog2(RATIO) : 1;

  logic [63:0]   r_acc;
  logic [63:0]   r_out;
  logic [IW-1:0] r_idx;
  logic [LW-1:0] r_num;
  logic          r_last;
  logic          r_full;

  logic          w_can;
  logic          w_accept;
  logic          w_complete;
  logic          w_fire;
  logic [63:0]   w_acc_wr;
  logic [63:0]   w_word;

  assign w_can      = ~rst & (~r_full | bus.out_canReceive);
  assign w_accept   = bus.in_isReady & w_can;
  assign w_complete = w_accept & ((r_idx == IW'(RATIO - 1)) | bus.in_isLast);
  assign w_fire     = r_full & bus.out_canReceive;

  // Accumulator with the current item dropped into lane r_idx
  always_comb begin
    w_acc_wr = r_acc;
    w_acc_wr[int'(r_idx) * IN_W +: IN_W] = bus.in;
  end

  always_comb begin
    w_word = w_acc_wr;
`ifdef STREAM_PACKER_ZERO_FILL_EN
    for (int l = 0; l < RATIO; l++) begin
      if (l > int'(r_idx)) begin
        w_word[l * IN_W +: IN_W] = '0;
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc  <= '0;
      r_out  <= '0;
      r_idx  <= '0;
      r_num  <= '0;
      r_last <= 1'b0;
      r_full <= 1'b0;
    end else if (w_complete) begin
      // A completing item overrides any same-cycle consume: the register reloads
      r_out  <= w_word;
      r_num  <= LW'(r_idx) + LW'(1);
      r_last <= bus.in_isLast;
      r_full <= 1'b1;
      r_idx  <= '0;
`ifdef STREAM_PACKER_ZERO_FILL_EN
      r_acc  <= '0;
`else
      r_acc  <= w_acc_wr;
`endif
    end else begin
      if (w_accept) begin
        r_acc <= w_acc_wr;
        r_idx <= r_idx + IW'(1);
      end
      if (w_fire) begin
        r_full <= 1'b0;
        r_num  <= '0;
        r_last <= 1'b0;
      end
    end
  end

  assign bus.in_canReceive = w_can;
  assign bus.out           = r_out;
  assign bus.out_isReady   = w_fire;
  assign bus.out_isLast    = r_last;
  assign bus.out_numLanes  = r_num;

endmodule

`default_nettype wire

// File: tb/tb_stream_packer.sv
//------------------------------------------------------------------------------
// tb_stream_packer : directed scoreboard bench for stream_packer (IN_W = 16).
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_stream_packer;
  localparam int IN_W = 16;
  localparam int LW   = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stream_packer_if #(.IN_W(IN_W)) bus();
  stream_packer #(.IN_W(IN_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [63:0]   data;
    logic [LW-1:0] lanes;
    logic          last;
  } word_t;

  word_t exp_q[$];
  int    pop_cyc[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    wait_cycles = 0;
  int    t0 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every presented word must match the head of the scoreboard
  always @(negedge clk) begin
    if (bus.out_isReady) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got data=%h lanes=%0d last=%0b, required no word",
                 bus.out, bus.out_numLanes, bus.out_isLast);
      end else begin
        word_t want;
        want = exp_q.pop_front();
        checks++;
        if ({bus.out, bus.out_numLanes, bus.out_isLast} !== want) begin
          errors++;
          $display("FAIL word: got data=%h lanes=%0d last=%0b, required data=%h lanes=%0d last=%0b",
                   bus.out, bus.out_numLanes, bus.out_isLast, want.data, want.lanes, want.last);
        end
        pop_cyc.push_back(cyc);
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, want);
    end
  endtask

  task automatic expect_word(input logic [63:0] d, input int n, input logic l);
    exp_q.push_back({d, LW'(n), l});
  endtask

  task automatic send(input logic [IN_W-1:0] d, input logic last);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.in_canReceive && n < 50) begin
      n++;
      @(negedge clk);
    end
    wait_cycles += n;
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_canReceive=0 for 50 cycles, required 1");
    end else begin
      bus.in         = d;
      bus.in_isLast  = last;
      bus.in_isReady = 1'b1;
      @(posedge clk);
      #1;
      bus.in_isReady = 1'b0;
      bus.in_isLast  = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion, required finish within 100us");
    $fatal(1);
  end

  initial begin
    bus.in             = '0;
    bus.in_isReady     = 1'b0;
    bus.in_isLast      = 1'b0;
    bus.out_canReceive = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_can",   64'(bus.in_canReceive), 64'd0);
    chk("rst_out",   bus.out, 64'd0);
    chk("rst_ready", 64'(bus.out_isReady), 64'd0);
    chk("rst_last",  64'(bus.out_isLast), 64'd0);
    chk("rst_lanes", 64'(bus.out_numLanes), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("can_after_release", 64'(bus.in_canReceive), 64'd1);

    // Single-item packet
    expect_word(64'h0000_0000_0000_ABCD, 1, 1'b1);
    send(16'hABCD, 1'b1);

    // Full four-item packet
    expect_word(64'h4444_3333_2222_1111, 4, 1'b1);
    send(16'h1111, 1'b0);
    send(16'h2222, 1'b0);
    send(16'h3333, 1'b0);
    send(16'h4444, 1'b1);

    // Six items: full word then partial word
    expect_word(64'h4444_3333_2222_1111, 4, 1'b0);
`ifdef STREAM_PACKER_ZERO_FILL_EN
    expect_word(64'h0000_0000_6666_5555, 2, 1'b1);
`else
    expect_word(64'h4444_3333_6666_5555, 2, 1'b1);
`endif
    send(16'h1111, 1'b0);
    send(16'h2222, 1'b0);
    send(16'h3333, 1'b0);
    send(16'h4444, 1'b0);
    send(16'h5555, 1'b0);
    send(16'h6666, 1'b1);
    repeat (3) @(posedge clk);

    // Backpressure for 5 cycles with a full word pending
    #1 bus.out_canReceive = 1'b0;
    expect_word(64'hA004_A003_A002_A001, 4, 1'b1);
    send(16'hA001, 1'b0);
    send(16'hA002, 1'b0);
    send(16'hA003, 1'b0);
    send(16'hA004, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_can", 64'(bus.in_canReceive), 64'd0);
      chk("stall_out", {bus.out[63:4], bus.out_numLanes, bus.out_isLast},
          {60'h_A004_A003_A002_A00, 3'd4, 1'b1});
    end
    @(posedge clk);
    #1 bus.out_canReceive = 1'b1;
    expect_word(64'hB004_B003_B002_B001, 4, 1'b1);
    send(16'hB001, 1'b0);
    send(16'hB002, 1'b0);
    send(16'hB003, 1'b0);
    send(16'hB004, 1'b1);
    repeat (3) @(posedge clk);

    // Twelve back-to-back items, words expected on cycles 5, 9, 13
    expect_word(64'h1004_1003_1002_1001, 4, 1'b0);
    expect_word(64'h1008_1007_1006_1005, 4, 1'b0);
    expect_word(64'h100C_100B_100A_1009, 4, 1'b1);
    pop_cyc.delete();
    wait_cycles = 0;
    @(posedge clk);
    #1 t0 = cyc;
    for (int k = 1; k <= 12; k++) begin
      send(16'h1000 + 16'(k), (k == 12));
    end
    repeat (3) @(posedge clk);
    chk("b2b_stall_cycles", 64'(wait_cycles), 64'd0);
    chk("b2b_word_count", 64'(pop_cyc.size()), 64'd3);
    for (int i = 0; i < 3 && i < pop_cyc.size(); i++) begin
      chk("b2b_word_cycle", 64'(pop_cyc[i] - t0 + 1), 64'(4 * (i + 1) + 1));
    end

    // Reset after two accepted items discards them
    send(16'hDEAD, 1'b0);
    send(16'hBEEF, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_can", 64'(bus.in_canReceive), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    expect_word(64'hC004_C003_C002_C001, 4, 1'b1);
    send(16'hC001, 1'b0);
    send(16'hC002, 1'b0);
    send(16'hC003, 1'b0);
    send(16'hC004, 1'b1);

    repeat (5) @(posedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
